// File: rtl/mips_pkg.sv
// Shared MIPS decode types: raw encodings, decoded ops, control bundle and decoded entry.
package mips_pkg;

    typedef logic [31:0] word_t;

    // Primary opcode field instr[31:26]
    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDIU = 6'h09,
        OP_SLTI  = 6'h0A,
        OP_SLTIU = 6'h0B,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_XORI  = 6'h0E,
        OP_LUI   = 6'h0F,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } raw_op_t;

    // R-type function field instr[5:0]
    typedef enum logic [5:0] {
        FN_SLL  = 6'h00,
        FN_SRL  = 6'h02,
        FN_SRA  = 6'h03,
        FN_JR   = 6'h08,
        FN_ADDU = 6'h21,
        FN_SUBU = 6'h23,
        FN_AND  = 6'h24,
        FN_OR   = 6'h25,
        FN_XOR  = 6'h26,
        FN_NOR  = 6'h27,
        FN_SLT  = 6'h2A,
        FN_SLTU = 6'h2B
    } raw_func_t;

    typedef enum logic [4:0] {
        DOP_RESERVED, DOP_ADDU, DOP_SUBU, DOP_SLT, DOP_SLTU, DOP_AND, DOP_NOR,
        DOP_OR, DOP_XOR, DOP_SLL, DOP_SRA, DOP_SRL, DOP_JR, DOP_ADDIU, DOP_SLTI,
        DOP_SLTIU, DOP_ANDI, DOP_LUI, DOP_BEQ, DOP_BNE, DOP_LW, DOP_SW, DOP_J,
        DOP_JAL, DOP_ORI, DOP_XORI
    } decoded_op_t;

    typedef struct packed {
        logic regwrite;
        logic alusrc;
        logic memread;
        logic memwrite;
        logic memtoreg;
        logic branch;
        logic jump;
    } control_t;

    typedef struct packed {
        decoded_op_t op;
        control_t    ctl;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  writereg;
        logic [4:0]  shamt;
        logic        shamt_valid;
        word_t       imm;
    } decoded_instr_t;

    // Control bundle per decoded op; RESERVED yields all zeros so the entry is inert downstream.
    function automatic control_t ctl_for(decoded_op_t op);
        control_t c;
        c = '0;
        case (op)
            DOP_ADDU, DOP_SUBU, DOP_SLT, DOP_SLTU, DOP_AND, DOP_NOR, DOP_OR,
            DOP_XOR, DOP_SLL, DOP_SRA, DOP_SRL: c.regwrite = 1'b1;
            DOP_ADDIU, DOP_SLTI, DOP_SLTIU, DOP_ANDI, DOP_ORI, DOP_XORI, DOP_LUI: begin
                c.regwrite = 1'b1;
                c.alusrc   = 1'b1;
            end
            DOP_LW: begin
                c.regwrite = 1'b1;
                c.alusrc   = 1'b1;
                c.memread  = 1'b1;
                c.memtoreg = 1'b1;
            end
            DOP_SW: begin
                c.alusrc   = 1'b1;
                c.memwrite = 1'b1;
            end
            DOP_BEQ, DOP_BNE: c.branch = 1'b1;
            DOP_J, DOP_JR:    c.jump = 1'b1;
            DOP_JAL: begin
                c.jump     = 1'b1;
                c.regwrite = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_slot.sv
// Combinational decoder for a single fetch slot: raw word in, decoded entry out.
module decode_slot
    import mips_pkg::*;
#(
    parameter int EXT_IMM = 1
) (
    input  word_t          instr,
    output decoded_instr_t dec
);

    decoded_op_t op;

    // Opcode/funct to decoded op; anything unrecognised becomes RESERVED.
    always_comb begin
        op = DOP_RESERVED;
        case (instr[31:26])
            OP_RTYPE: begin
                case (instr[5:0])
                    FN_ADDU: op = DOP_ADDU;
                    FN_SUBU: op = DOP_SUBU;
                    FN_SLT:  op = DOP_SLT;
                    FN_SLTU: op = DOP_SLTU;
                    FN_AND:  op = DOP_AND;
                    FN_NOR:  op = DOP_NOR;
                    FN_OR:   op = DOP_OR;
                    FN_XOR:  op = DOP_XOR;
                    FN_SLL:  op = DOP_SLL;
                    FN_SRA:  op = DOP_SRA;
                    FN_SRL:  op = DOP_SRL;
                    FN_JR:   op = DOP_JR;
                    default: op = DOP_RESERVED;
                endcase
            end
            OP_ADDIU: op = DOP_ADDIU;
            OP_SLTI:  op = DOP_SLTI;
            OP_SLTIU: op = DOP_SLTIU;
            OP_ANDI:  op = DOP_ANDI;
            OP_LUI:   op = DOP_LUI;
            OP_BEQ:   op = DOP_BEQ;
            OP_BNE:   op = DOP_BNE;
            OP_LW:    op = DOP_LW;
            OP_SW:    op = DOP_SW;
            OP_J:     op = DOP_J;
            OP_JAL:   op = DOP_JAL;
            OP_ORI:   op = (EXT_IMM != 0) ? DOP_ORI : DOP_RESERVED;
            OP_XORI:  op = (EXT_IMM != 0) ? DOP_XORI : DOP_RESERVED;
            default:  op = DOP_RESERVED;
        endcase
    end

    // Field extraction: destination register selection and immediate extension.
    always_comb begin
        dec             = '0;
        dec.op          = op;
        dec.ctl         = ctl_for(op);
        dec.rs          = instr[25:21];
        dec.rt          = instr[20:16];
        dec.shamt       = instr[10:6];
        dec.shamt_valid = (op == DOP_SLL) || (op == DOP_SRA) || (op == DOP_SRL);
        if (op == DOP_JAL)
            dec.writereg = 5'd31;
        else if (instr[31:26] == OP_RTYPE)
            dec.writereg = instr[15:11];
        else
            dec.writereg = instr[20:16];
        if ((op == DOP_ANDI) || (op == DOP_ORI) || (op == DOP_XORI))
            dec.imm = {16'h0000, instr[15:0]};
        else
            dec.imm = {{16{instr[15]}}, instr[15:0]};
    end

endmodule

// File: rtl/decode_queue.sv
// Buffered decode stage: decodes fetch groups on entry into a circular queue, presents oldest entries in order.
module decode_queue
    import mips_pkg::*;
#(
    parameter int FETCH_WIDTH = 2,
    parameter int ISSUE_WIDTH = 2,
    parameter int DEPTH       = 8,
    parameter int EXT_IMM     = 1,
    localparam int FW_W  = $clog2(FETCH_WIDTH + 1),
    localparam int IW_W  = $clog2(ISSUE_WIDTH + 1),
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic                                 flush,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [FW_W-1:0]                      in_cnt,
    input  word_t [FETCH_WIDTH-1:0]              in_instr,
    input  word_t [FETCH_WIDTH-1:0]              in_pc,
    output logic [ISSUE_WIDTH-1:0]               out_valid,
    output decoded_instr_t [ISSUE_WIDTH-1:0]     out_instr,
    output word_t [ISSUE_WIDTH-1:0]              out_pc,
    input  logic [IW_W-1:0]                      out_take,
    output logic [OCC_W-1:0]                     occupancy
);

    typedef struct packed {
        decoded_instr_t instr;
        word_t          pc;
    } entry_t;

    entry_t         mem [DEPTH];
    decoded_instr_t dec [FETCH_WIDTH];

    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [OCC_W-1:0] count_reg, count_next;
    logic             enq;
    logic [OCC_W-1:0] enq_cnt;
    logic [OCC_W-1:0] deq_cnt;

    genvar gi;
    generate
        for (gi = 0; gi < FETCH_WIDTH; gi++) begin : g_dec
            decode_slot #(.EXT_IMM(EXT_IMM)) u_slot (
                .instr(in_instr[gi]),
                .dec  (dec[gi])
            );
        end
    endgenerate

    // Ready only when a full group fits; derived from registered count so out_take cannot reach it.
    assign in_ready  = (OCC_W'(DEPTH) - count_reg) >= OCC_W'(FETCH_WIDTH);
    assign enq       = in_valid && in_ready && !flush;
    assign enq_cnt   = enq ? OCC_W'(in_cnt) : '0;
    assign deq_cnt   = OCC_W'(out_take);
    assign occupancy = count_reg;

    generate
        for (gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_out
            logic [PTR_W-1:0] rd_idx;
            assign rd_idx        = head_reg + PTR_W'(gi);
            assign out_valid[gi] = count_reg > OCC_W'(gi);
            assign out_instr[gi] = mem[rd_idx].instr;
            assign out_pc[gi]    = mem[rd_idx].pc;
        end
    endgenerate

    // Pointer/count update; flush wins over both enqueue and retire.
    always_comb begin
        head_next  = head_reg + PTR_W'(deq_cnt);
        tail_next  = tail_reg + PTR_W'(enq_cnt);
        count_next = count_reg + enq_cnt - deq_cnt;
        if (flush) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Entry storage: write the valid slots of an accepted group at tail onward; no reset needed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (enq && (i < int'(in_cnt)))
                mem[tail_reg + PTR_W'(i)] <= {dec[i], in_pc[i]};
        end
    end

    a_in_cnt_nonzero: assert property (@(posedge clk) disable iff (!resetn)
        in_valid |-> (in_cnt != '0));
    a_take_bounded: assert property (@(posedge clk) disable iff (!resetn)
        int'(out_take) <= $countones(out_valid));

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue with an in-order scoreboard of expected decoded entries.
module tb_decode_queue;
    import mips_pkg::*;

    logic                  clk;
    logic                  resetn;
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            in_cnt;
    word_t [1:0]           in_instr;
    word_t [1:0]           in_pc;
    logic [1:0]            out_valid;
    decoded_instr_t [1:0]  out_instr;
    word_t [1:0]           out_pc;
    logic [1:0]            out_take;
    logic [3:0]            occupancy;

    // second queue built with EXT_IMM=0
    logic                  in2_valid;
    logic                  in2_ready;
    logic [1:0]            in2_cnt;
    word_t [1:0]           in2_instr;
    word_t [1:0]           in2_pc;
    logic [1:0]            out2_valid;
    decoded_instr_t [1:0]  out2_instr;
    word_t [1:0]           out2_pc;
    logic [1:0]            out2_take;
    logic [3:0]            occupancy2;

    decode_queue #(.FETCH_WIDTH(2), .ISSUE_WIDTH(2), .DEPTH(8), .EXT_IMM(1)) dut (
        .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_cnt(in_cnt), .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid),
        .out_instr(out_instr), .out_pc(out_pc), .out_take(out_take), .occupancy(occupancy)
    );

    decode_queue #(.FETCH_WIDTH(2), .ISSUE_WIDTH(2), .DEPTH(8), .EXT_IMM(0)) dut_noext (
        .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in2_valid), .in_ready(in2_ready),
        .in_cnt(in2_cnt), .in_instr(in2_instr), .in_pc(in2_pc), .out_valid(out2_valid),
        .out_instr(out2_instr), .out_pc(out2_pc), .out_take(out2_take), .occupancy(occupancy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        word_t       pc;
        decoded_op_t op;
        logic [4:0]  wr;
    } exp_t;

    exp_t sb[$];
    int   model_occ;
    int   errors;
    int   checks;
    bit   wrap_mode;
    word_t wrap_pc;

    // instruction table with independently worked-out expected op and destination register
    word_t       tbl_instr [12] = '{32'h00851021, 32'h3C01ABCD, 32'h8C430004, 32'hAC430008,
                                    32'h1043FFFF, 32'h00021080, 32'h2402FFFF, 32'h08000010,
                                    32'h03E00008, 32'h3042FFFF, 32'h3422FFFF, 32'h0C000010};
    decoded_op_t tbl_op    [12] = '{DOP_ADDU, DOP_LUI, DOP_LW, DOP_SW, DOP_BEQ, DOP_SLL,
                                    DOP_ADDIU, DOP_J, DOP_JR, DOP_ANDI, DOP_ORI, DOP_JAL};
    logic [4:0]  tbl_wr    [12] = '{5'd2, 5'd1, 5'd3, 5'd3, 5'd3, 5'd2, 5'd2, 5'd0, 5'd0,
                                    5'd2, 5'd2, 5'd31};

    word_t       g_instr [2];
    word_t       g_pc    [2];
    decoded_op_t g_op    [2];
    logic [4:0]  g_wr    [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_slot(input int s, input int k, input word_t pc);
        g_instr[s] = tbl_instr[k];
        g_op[s]    = tbl_op[k];
        g_wr[s]    = tbl_wr[k];
        g_pc[s]    = pc;
    endtask

    // One cycle: check current outputs against the model, drive inputs, update the model, advance.
    task automatic step(input bit v, input int cnt, input int take, input bit fl);
        int   vis;
        int   added;
        exp_t e;
        vis = (model_occ < 2) ? model_occ : 2;
        check("occupancy", 32'(occupancy), 32'(model_occ));
        check("in_ready", 32'(in_ready), 32'((8 - model_occ) >= 2));
        check("out_valid", 32'(out_valid), 32'((1 << vis) - 1));
        for (int i = 0; i < vis; i++) begin
            check($sformatf("slot%0d_pc", i), out_pc[i], sb[i].pc);
            check($sformatf("slot%0d_op", i), 32'(out_instr[i].op), 32'(sb[i].op));
            check($sformatf("slot%0d_writereg", i), 32'(out_instr[i].writereg), 32'(sb[i].wr));
        end
        flush       = fl;
        in_valid    = v;
        in_cnt      = 2'(cnt);
        in_instr[0] = g_instr[0];
        in_instr[1] = g_instr[1];
        in_pc[0]    = g_pc[0];
        in_pc[1]    = g_pc[1];
        out_take    = 2'(take);
        if (fl) begin
            model_occ = 0;
            sb.delete();
        end else begin
            for (int i = 0; i < take; i++) begin
                e = sb.pop_front();
                if (wrap_mode) begin
                    check("wrap_pc_seq", out_pc[i], wrap_pc);
                    wrap_pc = wrap_pc + 32'd4;
                end
            end
            added = 0;
            if (v && ((8 - model_occ) >= 2)) begin
                for (int i = 0; i < cnt; i++) begin
                    e.pc = g_pc[i];
                    e.op = g_op[i];
                    e.wr = g_wr[i];
                    sb.push_back(e);
                end
                added = cnt;
            end
            model_occ = model_occ + added - take;
        end
        @(negedge clk);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int sent;
        int cnt;
        int take;
        int vis;
        int cyc;
        bit v;

        errors = 0; checks = 0; model_occ = 0; wrap_mode = 0; wrap_pc = '0;
        resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_cnt = 2'd1; out_take = 2'd0;
        in_instr = '0; in_pc = '0;
        in2_valid = 1'b0; in2_cnt = 2'd1; in2_instr = '0; in2_pc = '0; out2_take = 2'd0;
        set_slot(0, 0, 32'h0); set_slot(1, 0, 32'h0);
        repeat (2) @(negedge clk);

        // reset state
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        resetn = 1'b1;
        @(negedge clk);

        // addu + lui group, visible the following cycle
        set_slot(0, 0, 32'h100); set_slot(1, 1, 32'h104);
        step(1, 2, 0, 0);
        check("t2_out_valid", 32'(out_valid), 32'h3);
        check("t2_op0", 32'(out_instr[0].op), 32'(DOP_ADDU));
        check("t2_writereg0", 32'(out_instr[0].writereg), 32'd2);
        check("t2_op1", 32'(out_instr[1].op), 32'(DOP_LUI));
        check("t2_imm1", out_instr[1].imm, 32'hFFFFABCD);
        step(0, 1, 2, 0);

        // ori/jal on EXT_IMM=1, ori on EXT_IMM=0
        set_slot(0, 10, 32'h200); set_slot(1, 11, 32'h204);
        in2_valid = 1'b1; in2_cnt = 2'd1; in2_instr[0] = 32'h3422FFFF; in2_pc[0] = 32'h200;
        step(1, 2, 0, 0);
        in2_valid = 1'b0;
        check("t6_ori_op", 32'(out_instr[0].op), 32'(DOP_ORI));
        check("t6_ori_imm", out_instr[0].imm, 32'h0000FFFF);
        check("t6_jal_writereg", 32'(out_instr[1].writereg), 32'd31);
        check("t6_jal_regwrite", 32'(out_instr[1].ctl.regwrite), 32'd1);
        check("t6_noext_occupancy", 32'(occupancy2), 32'd1);
        check("t6_noext_op", 32'(out2_instr[0].op), 32'(DOP_RESERVED));
        check("t6_noext_ctl", 32'(out2_instr[0].ctl), 32'd0);
        step(0, 1, 2, 0);

        // fill to 7 entries, in_ready drops, one retire brings it back
        for (int g = 0; g < 3; g++) begin
            set_slot(0, (2 * g) % 12, 32'h300 + 32'(8 * g));
            set_slot(1, (2 * g + 1) % 12, 32'h304 + 32'(8 * g));
            step(1, 2, 0, 0);
        end
        set_slot(0, 6, 32'h318);
        step(1, 1, 0, 0);
        check("t3_occupancy7", 32'(occupancy), 32'd7);
        check("t3_ready_low", 32'(in_ready), 32'd0);
        set_slot(0, 7, 32'h31C); set_slot(1, 8, 32'h320);
        step(1, 2, 0, 0);
        check("t3_blocked_occupancy", 32'(occupancy), 32'd7);
        step(0, 1, 1, 0);
        check("t3_ready_back", 32'(in_ready), 32'd1);
        check("t3_occupancy6", 32'(occupancy), 32'd6);
        repeat (3) step(0, 1, 2, 0);

        // flush beats simultaneous enqueue and retire
        set_slot(0, 2, 32'h400); set_slot(1, 3, 32'h404);
        step(1, 2, 0, 0);
        set_slot(0, 4, 32'h408); set_slot(1, 5, 32'h40C);
        step(1, 2, 1, 1);
        check("t5_occupancy", 32'(occupancy), 32'd0);
        check("t5_out_valid", 32'(out_valid), 32'd0);
        set_slot(0, 9, 32'h500);
        step(1, 1, 0, 0);
        step(0, 1, 1, 0);

        // 20 sequential instructions across pointer wrap with random retire
        wrap_mode = 1; wrap_pc = 32'h0; sent = 0; cyc = 0;
        while ((sent < 20 || model_occ > 0) && cyc < 300) begin
            v = (sent < 20) && ((8 - model_occ) >= 2) && ($urandom_range(0, 4) != 0);
            cnt = 20 - sent;
            if (cnt > 2) cnt = 2;
            if (cnt == 2 && $urandom_range(0, 3) == 0) cnt = 1;
            if (v) begin
                set_slot(0, sent % 12, 32'(sent * 4));
                if (cnt == 2) set_slot(1, (sent + 1) % 12, 32'((sent + 1) * 4));
            end
            vis = (model_occ < 2) ? model_occ : 2;
            take = $urandom_range(0, vis);
            step(v, v ? cnt : 1, take, 0);
            if (v) sent += cnt;
            cyc++;
        end
        wrap_mode = 0;
        check("t4_all_retired", wrap_pc, 32'h50);

        // asynchronous reset in the middle of traffic
        set_slot(0, 0, 32'h600); set_slot(1, 1, 32'h604);
        step(1, 2, 0, 0);
        set_slot(0, 2, 32'h608); set_slot(1, 3, 32'h60C);
        step(1, 2, 0, 0);
        set_slot(0, 4, 32'h610);
        step(1, 1, 0, 0);
        check("t1_occupancy5", 32'(occupancy), 32'd5);
        in_valid = 1'b1; in_cnt = 2'd2; out_take = 2'd1;
        #2 resetn = 1'b0;
        #1;
        check("t1_async_occupancy", 32'(occupancy), 32'd0);
        check("t1_async_out_valid", 32'(out_valid), 32'd0);
        check("t1_async_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0; in_cnt = 2'd1; out_take = 2'd0;
        model_occ = 0;
        sb.delete();
        @(negedge clk);
        resetn = 1'b1;
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
